// File: rtl/instr_loader.sv
// instr_loader: boot-time program loader for the core's instruction memory.
// Takes a framed byte stream (16-bit big-endian word count, 4*N payload bytes
// MSB first, one XOR checksum byte), writes each assembled 32-bit word to the
// instruction memory, and keeps the core in reset until a frame whose
// checksum matches has been loaded.
module instr_loader #(
  parameter int DATA_WIDTH      = 32,
  parameter int INSTR_MEM_DEPTH = 1024
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start,
  input  logic [7:0]            in_byte,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  WE,
  output logic [31:0]           A,
  output logic [DATA_WIDTH-1:0] WD,
  output logic                  core_rst,
  output logic                  done,
  output logic                  error,
  output logic [15:0]           words_loaded
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR_HI = 3'd1,
    ST_HDR_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_CHECK  = 3'd5,
    ST_DONE   = 3'd6,
    ST_ERROR  = 3'd7
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   n_q, n_d;              // word count from the header
  logic [1:0]    byte_idx_q, byte_idx_d; // byte position inside the current word
  logic [23:0]   word_q, word_d;        // first three bytes of the current word
  logic [7:0]    csum_q, csum_d;        // running XOR of payload bytes
  logic [15:0]   wl_q, wl_d;            // words written so far (also next word index)
  logic [31:0]   a_q, a_d;
  logic [31:0]   wd_q, wd_d;
  logic          we_q, we_d;
  logic          rdy_q, rdy_d;
  logic          core_rst_q, core_rst_d;
  logic          done_q, done_d;
  logic          error_q, error_d;

  logic          accept;
  logic [15:0]   n_full;

  // A byte is consumed only when the registered ready is up.
  assign accept = in_valid && rdy_q;
  // Complete header value as it will be once the low byte is taken.
  assign n_full = {n_q[15:8], in_byte};

  // Next-state, datapath and word-assembly logic.
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    csum_d     = csum_q;
    wl_d       = wl_q;
    a_d        = a_q;
    wd_d       = wd_q;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        // A new frame starts from a clean slate; the previous count stays
        // visible until then.
        if (start) begin
          state_d    = ST_HDR_HI;
          wl_d       = 16'd0;
          csum_d     = 8'd0;
          byte_idx_d = 2'd0;
        end
      end

      ST_HDR_HI: begin
        if (accept) begin
          n_d     = {in_byte, n_q[7:0]};
          state_d = ST_HDR_LO;
        end
      end

      ST_HDR_LO: begin
        if (accept) begin
          n_d = n_full;
          if ({16'd0, n_full} > 32'(INSTR_MEM_DEPTH)) begin
            state_d = ST_ERROR;
          end else if (n_full == 16'd0) begin
            state_d = ST_CHECK;
          end else begin
            state_d = ST_DATA;
          end
        end
      end

      ST_DATA: begin
        if (accept) begin
          csum_d     = csum_q ^ in_byte;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            // Fourth byte completes the word: present it to the memory
            // together with its byte address in the following cycle.
            wd_d    = {word_q, in_byte};
            a_d     = {14'd0, wl_q, 2'b00};
            wl_d    = wl_q + 16'd1;
            state_d = ST_WRITE;
          end else begin
            word_d = {word_q[15:0], in_byte};
          end
        end
      end

      ST_WRITE: begin
        // wl_q was already advanced past this word.
        if (wl_q == n_q) begin
          state_d = ST_CHECK;
        end else begin
          state_d = ST_DATA;
        end
      end

      ST_CHECK: begin
        if (accept) begin
          if (in_byte == csum_q) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ERROR;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state so every output is a flop that
  // lines up with the state it belongs to.
  always_comb begin
    rdy_d      = (state_d == ST_HDR_HI) || (state_d == ST_HDR_LO) ||
                 (state_d == ST_DATA)   || (state_d == ST_CHECK);
    we_d       = (state_d == ST_WRITE);
    core_rst_d = (state_d != ST_DONE);
    done_d     = (state_d == ST_DONE);
    error_d    = (state_d == ST_ERROR);
  end

  // State and registered outputs; reset aborts any frame in flight.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      n_q        <= 16'd0;
      byte_idx_q <= 2'd0;
      word_q     <= 24'd0;
      csum_q     <= 8'd0;
      wl_q       <= 16'd0;
      a_q        <= 32'd0;
      wd_q       <= 32'd0;
      we_q       <= 1'b0;
      rdy_q      <= 1'b0;
      core_rst_q <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      csum_q     <= csum_d;
      wl_q       <= wl_d;
      a_q        <= a_d;
      wd_q       <= wd_d;
      we_q       <= we_d;
      rdy_q      <= rdy_d;
      core_rst_q <= core_rst_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign in_ready     = rdy_q;
  assign WE           = we_q;
  assign A            = a_q;
  assign WD           = wd_q[DATA_WIDTH-1:0];
  assign core_rst     = core_rst_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = wl_q;

endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: directed frames against a byte-position model of the
// loader, compared on every cycle, plus literal checks per scenario.
module tb_instr_loader;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  in_byte = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready, WE, core_rst, done, error;
  logic [31:0] A, WD;
  logic [15:0] words_loaded;

  instr_loader #(.DATA_WIDTH(32), .INSTR_MEM_DEPTH(1024)) dut (
    .CLK(CLK), .RST(RST), .start(start), .in_byte(in_byte),
    .in_valid(in_valid), .in_ready(in_ready), .WE(WE), .A(A), .WD(WD),
    .core_rst(core_rst), .done(done), .error(error),
    .words_loaded(words_loaded)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: frame interpreted by byte position -------------
  int          m_status = 0;   // 0 idle after reset, 1 loading, 2 done, 3 error
  int          nb = 0;         // bytes accepted in this frame
  int          n_words = 0;
  logic [7:0]  n_hi = 8'h00;
  logic [7:0]  xr = 8'h00;
  logic [31:0] cur = 32'h0;
  logic [31:0] exp_a = 32'h0;
  logic [31:0] exp_wd = 32'h0;
  int          exp_wl = 0;
  bit          pend_we = 1'b0;
  logic        exp_rdy;
  int          we_cnt = 0;
  logic [31:0] log_a [16];
  logic [31:0] log_wd [16];

  always @(negedge CLK) begin
    if (RST) begin
      m_status = 0; nb = 0; exp_wl = 0; pend_we = 1'b0;
      exp_a = 32'h0; exp_wd = 32'h0; xr = 8'h00;
    end
    exp_rdy = (m_status == 1) && !pend_we;
    chk("WE", 32'(WE), 32'(pend_we));
    chk("A", A, exp_a);
    chk("WD", WD, exp_wd);
    chk("words_loaded", 32'(words_loaded), 32'(exp_wl));
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("done", 32'(done), 32'(m_status == 2));
    chk("error", 32'(error), 32'(m_status == 3));
    chk("core_rst", 32'(core_rst), 32'(m_status != 2));
    if (WE === 1'b1) begin
      log_a[we_cnt % 16]  = A;
      log_wd[we_cnt % 16] = WD;
      we_cnt++;
      $display("write A=%h WD=%h words_loaded=%0d", A, WD, words_loaded);
    end
    if (!RST) begin
      if (pend_we) begin
        pend_we = 1'b0;
      end else if (start && m_status != 1) begin
        m_status = 1; nb = 0; xr = 8'h00; exp_wl = 0;
      end else if (in_valid && exp_rdy) begin
        if (nb == 0) begin
          n_hi = in_byte;
        end else if (nb == 1) begin
          n_words = int'({n_hi, in_byte});
          if (n_words > 1024) m_status = 3;
        end else if (nb < 2 + 4 * n_words) begin
          xr  = xr ^ in_byte;
          cur = {cur[23:0], in_byte};
          if ((nb - 2) % 4 == 3) begin
            pend_we = 1'b1;
            exp_a   = 32'(4 * ((nb - 2) / 4));
            exp_wd  = cur;
            exp_wl++;
          end
        end else begin
          m_status = (in_byte == xr) ? 2 : 3;
        end
        nb++;
      end
    end
  end

  // ---------------- stimulus ----------------------------------------------
  bit          gap_en = 1'b0;
  bit          inj_en = 1'b0;
  logic [31:0] fw [4];

  task automatic step();
    @(posedge CLK); #2;
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic rdy;
    bit   got;
    got = 1'b0;
    if (gap_en) begin
      repeat ($urandom_range(0, 3)) begin
        in_valid = 1'b0; in_byte = 8'hFF;
        start = inj_en && ($urandom_range(0, 2) == 0);
        step();
        start = 1'b0;
      end
    end
    in_valid = 1'b1; in_byte = b;
    for (int t = 0; t < 100 && !got; t++) begin
      @(negedge CLK); rdy = in_ready;
      step();
      if (rdy) got = 1'b1;
    end
    in_valid = 1'b0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL accept_timeout actual=no_accept required=accept byte=%h", b);
    end
  endtask

  task automatic send_frame(input logic [15:0] n, input int nw,
                            input logic [7:0] cks, input bit with_cks);
    pulse_start();
    send_byte(n[15:8]);
    send_byte(n[7:0]);
    for (int w = 0; w < nw; w++)
      for (int bi = 3; bi >= 0; bi--) send_byte(8'(fw[w] >> (8 * bi)));
    if (with_cks) send_byte(cks);
  endtask

  task automatic wait_end(input string name);
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 50 && !seen; t++) begin
      @(negedge CLK);
      if (done || error) seen = 1'b1;
    end
    step();
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s_timeout actual=no_end required=done_or_error", name);
    end
    $display("frame %s done=%0b error=%0b core_rst=%0b words_loaded=%0d",
             name, done, error, core_rst, words_loaded);
  endtask

  int base;

  initial begin
    repeat (3) step();
    chk("rst_core_rst", 32'(core_rst), 32'h1);
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    RST = 1'b0;
    step();

    // 1: two words, good checksum 0x0F
    fw[0] = 32'h20100005; fw[1] = 32'h2010000A;
    base = we_cnt;
    send_frame(16'd2, 2, 8'h0F, 1'b1);
    wait_end("good2");
    chk("s1_done", 32'(done), 32'h1);
    chk("s1_core_rst", 32'(core_rst), 32'h0);
    chk("s1_wl", 32'(words_loaded), 32'd2);
    chk("s1_we_cnt", 32'(we_cnt - base), 32'd2);
    chk("s1_a0", log_a[base % 16], 32'h0);
    chk("s1_wd0", log_wd[base % 16], 32'h20100005);
    chk("s1_a1", log_a[(base + 1) % 16], 32'h4);
    chk("s1_wd1", log_wd[(base + 1) % 16], 32'h2010000A);

    // 2: same frame, corrupted checksum
    base = we_cnt;
    send_frame(16'd2, 2, 8'h0E, 1'b1);
    wait_end("badcks");
    chk("s2_error", 32'(error), 32'h1);
    chk("s2_done", 32'(done), 32'h0);
    chk("s2_core_rst", 32'(core_rst), 32'h1);
    chk("s2_we_cnt", 32'(we_cnt - base), 32'd2);

    // 3: oversize header
    base = we_cnt;
    send_frame(16'h0401, 0, 8'h00, 1'b0);
    wait_end("oversize");
    chk("s3_error", 32'(error), 32'h1);
    chk("s3_we_cnt", 32'(we_cnt - base), 32'd0);

    // 4: empty frame, good then bad checksum
    base = we_cnt;
    send_frame(16'd0, 0, 8'h00, 1'b1);
    wait_end("empty_good");
    chk("s4_done", 32'(done), 32'h1);
    chk("s4_wl", 32'(words_loaded), 32'd0);
    chk("s4_we_cnt", 32'(we_cnt - base), 32'd0);
    send_frame(16'd0, 0, 8'h5A, 1'b1);
    wait_end("empty_bad");
    chk("s4b_error", 32'(error), 32'h1);

    // 5: gaps plus start pulses mid-frame
    gap_en = 1'b1; inj_en = 1'b1;
    base = we_cnt;
    send_frame(16'd2, 2, 8'h0F, 1'b1);
    gap_en = 1'b0; inj_en = 1'b0;
    wait_end("gappy");
    chk("s5_done", 32'(done), 32'h1);
    chk("s5_we_cnt", 32'(we_cnt - base), 32'd2);
    chk("s5_wd0", log_wd[base % 16], 32'h20100005);
    chk("s5_wd1", log_wd[(base + 1) % 16], 32'h2010000A);
    chk("s5_a1", log_a[(base + 1) % 16], 32'h4);

    // 6: reset after the first of three words is written
    fw[0] = 32'h11223344; fw[1] = 32'h55667788; fw[2] = 32'h99AABBCC;
    pulse_start();
    send_byte(8'h00); send_byte(8'h03);
    for (int bi = 3; bi >= 0; bi--) send_byte(8'(fw[0] >> (8 * bi)));
    step();
    RST = 1'b1;
    step(); step();
    chk("s6_rst_A", A, 32'h0);
    chk("s6_rst_WD", WD, 32'h0);
    chk("s6_rst_core_rst", 32'(core_rst), 32'h1);
    chk("s6_rst_wl", 32'(words_loaded), 32'd0);
    RST = 1'b0;
    base = we_cnt;
    repeat (4) step();
    chk("s6_quiet", 32'(we_cnt - base), 32'd0);
    fw[0] = 32'h20100005; fw[1] = 32'h2010000A;
    send_frame(16'd2, 2, 8'h0F, 1'b1);
    wait_end("after_rst");
    chk("s6_done", 32'(done), 32'h1);
    chk("s6_a0", log_a[base % 16], 32'h0);
    chk("s6_wd0", log_wd[base % 16], 32'h20100005);
    chk("s6_wl", 32'(words_loaded), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
